// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter_if
// Purpose  : Requester and SRAM-side bus bundle for sram_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          inst_done;

    logic          data_req;
    logic [3:0]    data_wen;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          data_done;

    logic          sram_en;
    logic [3:0]    sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    // Arbiter view
    modport slave (
        input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
        output inst_rdata, inst_done, data_rdata, data_done,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );

    // Requester / SRAM environment view
    modport master (
        output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
        input  inst_rdata, inst_done, data_rdata, data_done,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Purpose  : Shares one synchronous SRAM between instruction fetch and data
//            access; one access per grant, read data returned next cycle.
//            Define SRAM_ARB_RR_EN for round-robin conflict resolution,
//            otherwise data wins IDLE conflicts.
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input wire                 clk,
    input wire                 resetn,
    sram_port_arbiter_if.slave bus
);

    localparam logic [AW-1:0] C_ZERO_A = '0;
    localparam logic [DW-1:0] C_ZERO_D = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_last_grant;
    logic   w_inst_elig;
    logic   w_data_elig;
    logic   w_pick_data;
    logic   w_grant_i;
    logic   w_grant_d;

    // A requester in its done cycle still holds req for the finished access.
    assign w_inst_elig = bus.inst_req & (r_state != ST_BUSY_I);
    assign w_data_elig = bus.data_req & (r_state != ST_BUSY_D);

`ifdef SRAM_ARB_RR_EN
    assign w_pick_data = ~r_last_grant;
`else
    // Data always wins; last_grant is tracked but cannot change the outcome.
    assign w_pick_data = r_last_grant | 1'b1;
`endif

    assign w_grant_d = w_data_elig & (~w_inst_elig | w_pick_data);
    assign w_grant_i = w_inst_elig & ~w_grant_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_i | w_grant_d) begin
                r_last_grant <= w_grant_d;
            end
        end
    end

    always_comb begin
        w_next_state   = ST_IDLE;
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'b0000;
        bus.sram_addr  = C_ZERO_A;
        bus.sram_wdata = C_ZERO_D;
        bus.inst_done  = 1'b0;
        bus.inst_rdata = C_ZERO_D;
        bus.data_done  = 1'b0;
        bus.data_rdata = C_ZERO_D;

        if (w_grant_d) begin
            w_next_state = ST_BUSY_D;
        end else if (w_grant_i) begin
            w_next_state = ST_BUSY_I;
        end

        // Outputs are forced low for as long as reset is held.
        if (resetn) begin
            if (w_grant_d) begin
                bus.sram_en    = 1'b1;
                bus.sram_wen   = bus.data_wen;
                bus.sram_addr  = bus.data_addr;
                bus.sram_wdata = bus.data_wdata;
            end else if (w_grant_i) begin
                bus.sram_en    = 1'b1;
                bus.sram_addr  = bus.inst_addr;
            end

            case (r_state)
                ST_BUSY_I: begin
                    bus.inst_done  = 1'b1;
                    bus.inst_rdata = bus.sram_rdata;
                end
                ST_BUSY_D: begin
                    bus.data_done  = 1'b1;
                    bus.data_rdata = bus.sram_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
